mem_access_initiator: RTL

- Requester-side client of the multi-reader/single-writer storage pool, used by the RV32I multicycle core's load/store stage.
- Accepts one byte-addressed RV32I load or store per transaction and converts it into word-wide pool requests.
  - Reads: hold a read enable until the pool grants via readfin.
  - Writes: single-cycle write enable.
  - SB/SH: read-modify-write.
- Returns sign- or zero-extended load data and a one-cycle completion pulse.

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/byte_lane_unit.sv | 41 ++++
 rtl/mem_access_initiator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants and types for the load/store pool initiator.
// Holds width codes, FSM encoding and the wait-counter sizing helper.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ_REQ,
        WRITE,
        DONE
    } state_t;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte/halfword lane extraction with extension, and store-lane merge.
// Purely combinational; shared by the load and RMW store paths.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] row,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = row[{offset, 3'b000} +: 8];
        half_v    = offset[1] ? row[31:16] : row[15:0];
        load_data = row;
        unique case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'd0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'd0, half_v};
            default: load_data = row;
        endcase
    end

    always_comb begin
        merged = row;
        if (funct3 == F3_B) begin
            merged[{offset, 3'b000} +: 8] = store_data[7:0];
        end else if (offset[1]) begin
            merged[31:16] = store_data;
        end else begin
            merged[15:0] = store_data;
        end
    end

endmodule

// File: rtl/mem_access_initiator.sv
// Load/store client of the shared storage pool: one RV32I access per
// transaction, RMW for sub-word stores, bounded wait for read grants.
module mem_access_initiator
    import mem_access_pkg::*;
#(
    parameter int READ_ADDR_SIZE = 28,
    parameter int ROW_WIDTH      = 32,
    parameter int WAIT_LIMIT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      startSig,
    input  logic                      isStore,
    input  logic [2:0]                funct3,
    input  logic [31:0]               byteAddr,
    input  logic [31:0]               storeData,
    output logic [READ_ADDR_SIZE-1:0] readAddr,
    output logic                      readEn,
    input  logic                      readfin,
    input  logic [ROW_WIDTH-1:0]      poolReadData,
    output logic [READ_ADDR_SIZE-1:0] writeAddr,
    output logic [ROW_WIDTH-1:0]      writeData,
    output logic                      writeEn,
    output logic [31:0]               loadData,
    output logic                      finSig,
    output logic                      errSig,
    output logic                      busy
);

    localparam int CW = cnt_width(WAIT_LIMIT);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            st;
    logic [2:0]      f3;
    logic [1:0]      addr_lo;
    logic [31:0]     sdata;
    logic            err;
    logic            legal;
    logic            timeout;
    logic [31:0]     lane_load;
    logic [31:0]     lane_merge;
    logic            unused_hi;

    assign unused_hi = ^byteAddr[31:READ_ADDR_SIZE+2];
    assign cnt_n     = cnt + CW'(1);
    assign timeout   = (cnt_n == CW'(WAIT_LIMIT));

    byte_lane_unit u_lane (
        .funct3     (f3),
        .offset     (addr_lo),
        .row        (poolReadData),
        .store_data (sdata[15:0]),
        .load_data  (lane_load),
        .merged     (lane_merge)
    );

    always_comb begin
        legal = 1'b0;
        unique case (f3)
            F3_B, F3_BU: legal = 1'b1;
            F3_H, F3_HU: legal = ~addr_lo[0];
            F3_W:        legal = (addr_lo == 2'b00);
            default:     legal = 1'b0;
        endcase
        // Stores only have B/H/W encodings
        if (st && f3[2]) legal = 1'b0;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (startSig) state_n = CHECK;
            CHECK: begin
                if (!legal)                  state_n = DONE;
                else if (st && f3 == F3_W)   state_n = WRITE;
                else                         state_n = READ_REQ;
            end
            READ_REQ: begin
                if (readfin)      state_n = st ? WRITE : DONE;
                else if (timeout) state_n = DONE;
            end
            WRITE:    state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            st        <= 1'b0;
            f3        <= 3'b000;
            addr_lo   <= 2'b00;
            sdata     <= '0;
            err       <= 1'b0;
            readAddr  <= '0;
            writeAddr <= '0;
            writeData <= '0;
            loadData  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (startSig) begin
                        st        <= isStore;
                        f3        <= funct3;
                        addr_lo   <= byteAddr[1:0];
                        sdata     <= storeData;
                        err       <= 1'b0;
                        cnt       <= '0;
                        readAddr  <= byteAddr[READ_ADDR_SIZE+1:2];
                        writeAddr <= byteAddr[READ_ADDR_SIZE+1:2];
                    end
                end
                CHECK: begin
                    if (!legal)                err       <= 1'b1;
                    else if (st && f3 == F3_W) writeData <= sdata;
                end
                READ_REQ: begin
                    if (readfin) begin
                        cnt <= '0;
                        if (st) writeData <= lane_merge;
                        else    loadData  <= lane_load;
                    end else if (timeout) begin
                        cnt <= '0;
                        err <= 1'b1;
                    end else begin
                        cnt <= cnt_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign readEn  = (state == READ_REQ);
    assign writeEn = (state == WRITE);
    assign finSig  = (state == DONE);
    assign errSig  = (state == DONE) && err;
    assign busy    = (state != IDLE);

endmodule
